riscv_run_ctrl: RTL and testbench

Run controller sitting between the RISC-V IP's AXI4-Lite register slave and the RISC-V core plus its instruction memory. It turns the register-level run/instruction-write controls into a sequenced core run:
- loads instruction words into memory while the core is stopped;
- releases the core from reset for a programmed cycle budget or until the core halts;
- reports idle/running/done status and the elapsed cycle count back to the register file.

---
 rtl/riscv_ctrl_pkg.sv | 14 +
 rtl/riscv_run_ctrl_if.sv | 39 +++
 rtl/riscv_edge_det.sv | 18 +
 rtl/riscv_run_ctrl.sv | 118 +++++++++++
 tb/tb_riscv_run_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and constants for the RISC-V run controller
package riscv_ctrl_pkg;

  localparam int DEF_IMEM_AW = 10;
  localparam int DATA_W      = 32;
  localparam logic [DATA_W-1:0] ELAPSED_SAT = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// rtl/riscv_run_ctrl_if.sv - register-side controls plus core/imem side of the run controller
interface riscv_run_ctrl_if #(
  parameter int IMEM_AW = riscv_ctrl_pkg::DEF_IMEM_AW
);

  logic                          i_run;
  logic [riscv_ctrl_pkg::DATA_W-1:0] i_num_cycle;
  logic                          i_mem_reset_n;
  logic                          i_instr_write;
  logic [31:0]                   i_instr_data;
  logic [31:0]                   i_instr_addr;
  logic                          i_core_halt;
  logic                          o_core_rst;
  logic                          o_core_en;
  logic                          o_imem_we;
  logic [IMEM_AW-1:0]            o_imem_addr;
  logic [31:0]                   o_imem_wdata;
  logic                          o_idle;
  logic                          o_running;
  logic                          o_done;
  logic                          o_halted;
  logic                          o_addr_err;
  logic [riscv_ctrl_pkg::DATA_W-1:0] o_elapsed;

  modport host (
    output i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_data,
           i_instr_addr, i_core_halt,
    input  o_core_rst, o_core_en, o_imem_we, o_imem_addr, o_imem_wdata,
           o_idle, o_running, o_done, o_halted, o_addr_err, o_elapsed
  );

  modport ctrl (
    input  i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_data,
           i_instr_addr, i_core_halt,
    output o_core_rst, o_core_en, o_imem_we, o_imem_addr, o_imem_wdata,
           o_idle, o_running, o_done, o_halted, o_addr_err, o_elapsed
  );

endinterface

// File: rtl/riscv_edge_det.sv
// rtl/riscv_edge_det.sv - 1-bit rising-edge detector against a one-cycle delayed copy
module riscv_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// rtl/riscv_run_ctrl.sv - sequences instruction loads and budgeted/halt-terminated core runs
module riscv_run_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int IMEM_AW = DEF_IMEM_AW
) (
  input  logic s00_axi_aclk,
  input  logic s00_axi_areset,
  riscv_run_ctrl_if.ctrl bus
);

  run_state_t        state_q, state_d;
  logic              run_rise, wr_rise;
  logic [DATA_W-1:0] budget_q, elapsed_q, elapsed_inc;
  logic              budget_hit, wr_oob;
  logic              core_rst_q, core_en_q, idle_q, running_q, done_q;
  logic              halted_q, addr_err_q, imem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;

  riscv_edge_det u_run_edge (
    .clk (s00_axi_aclk), .rst (s00_axi_areset), .d (bus.i_run), .rise (run_rise)
  );

  riscv_edge_det u_wr_edge (
    .clk (s00_axi_aclk), .rst (s00_axi_areset), .d (bus.i_instr_write), .rise (wr_rise)
  );

  assign elapsed_inc = (elapsed_q == ELAPSED_SAT) ? ELAPSED_SAT : elapsed_q + 1'b1;
  assign budget_hit  = (budget_q != '0) && (elapsed_inc == budget_q);
  assign wr_oob      = |bus.i_instr_addr[31:IMEM_AW+2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_rise) state_d = RUN;
      RUN:     if (bus.i_core_halt || budget_hit) state_d = DONE;
      DONE:    if (!bus.i_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!bus.i_mem_reset_n) state_d = IDLE;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status and core controls are registered from the next state so they change with it.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      idle_q       <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      budget_q     <= '0;
      elapsed_q    <= '0;
      halted_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      core_rst_q <= (state_d != RUN);
      core_en_q  <= (state_d == RUN);
      idle_q     <= (state_d == IDLE);
      running_q  <= (state_d == RUN);
      done_q     <= (state_d == DONE);
      imem_we_q  <= 1'b0;
      if (!bus.i_mem_reset_n) begin
        elapsed_q  <= '0;
        halted_q   <= 1'b0;
        addr_err_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (run_rise) begin
            budget_q   <= bus.i_num_cycle;
            elapsed_q  <= '0;
            halted_q   <= 1'b0;
            addr_err_q <= 1'b0;
          end
          RUN: begin
            elapsed_q <= elapsed_inc;
            if (bus.i_core_halt) halted_q <= 1'b1;
          end
          default: ;
        endcase
        // Writes are only legal while the core is held in reset.
        if (wr_rise && state_q != RUN) begin
          if (wr_oob) begin
            addr_err_q <= 1'b1;
          end else begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= bus.i_instr_addr[IMEM_AW+1:2];
            imem_wdata_q <= bus.i_instr_data;
          end
        end
      end
    end
  end

  assign bus.o_core_rst   = core_rst_q;
  assign bus.o_core_en    = core_en_q;
  assign bus.o_imem_we    = imem_we_q;
  assign bus.o_imem_addr  = imem_addr_q;
  assign bus.o_imem_wdata = imem_wdata_q;
  assign bus.o_idle       = idle_q;
  assign bus.o_running    = running_q;
  assign bus.o_done       = done_q;
  assign bus.o_halted     = halted_q;
  assign bus.o_addr_err   = addr_err_q;
  assign bus.o_elapsed    = elapsed_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb/tb_riscv_run_ctrl.sv - self-checking bench for riscv_run_ctrl
module tb_riscv_run_ctrl;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic exp_err = 1'b0;

  riscv_run_ctrl_if #(.IMEM_AW(AW)) bus ();

  riscv_run_ctrl #(.IMEM_AW(AW)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic oob;
    oob = (addr >= 32'h1000);
    bus.i_instr_addr  = addr;
    bus.i_instr_data  = data;
    bus.i_instr_write = 1'b1;
    step();
    if (oob) exp_err = 1'b1;
    check({tag, "_we"}, bus.o_imem_we, !oob);
    if (!oob) begin
      check({tag, "_addr"}, bus.o_imem_addr, addr / 4);
      check({tag, "_data"}, bus.o_imem_wdata, data);
    end
    check({tag, "_err"}, bus.o_addr_err, exp_err);
    check({tag, "_idle"}, bus.o_idle, 1);
    bus.i_instr_write = 1'b0;
    step();
    check({tag, "_we_off"}, bus.o_imem_we, 0);
  endtask

  // Expected outcome comes from the rule: the run ends at whichever of halt or budget comes first.
  task automatic do_run(input string tag, input int budget, input int halt_cyc);
    int   exp_el, en_cnt, n;
    logic exp_h;
    if (halt_cyc != 0 && (budget == 0 || halt_cyc <= budget)) begin
      exp_el = halt_cyc;
      exp_h  = 1'b1;
    end else begin
      exp_el = budget;
      exp_h  = 1'b0;
    end
    bus.i_num_cycle = budget;
    bus.i_run = 1'b1;
    step();
    exp_err = 1'b0;
    check({tag, "_running"}, bus.o_running, 1);
    check({tag, "_core_rst"}, bus.o_core_rst, 0);
    check({tag, "_el0"}, bus.o_elapsed, 0);
    en_cnt = 0;
    n = 0;
    while (!bus.o_done && n < 300) begin
      en_cnt += int'(bus.o_core_en);
      n++;
      bus.i_core_halt = (n == halt_cyc);
      step();
    end
    bus.i_core_halt = 1'b0;
    check({tag, "_done"}, bus.o_done, 1);
    check({tag, "_en_cycles"}, en_cnt, exp_el);
    check({tag, "_elapsed"}, bus.o_elapsed, exp_el);
    check({tag, "_halted"}, bus.o_halted, exp_h);
    check({tag, "_en_off"}, bus.o_core_en, 0);
    check({tag, "_err_clr"}, bus.o_addr_err, 0);
    bus.i_run = 1'b0;
    step();
    check({tag, "_idle"}, bus.o_idle, 1);
    check({tag, "_el_hold"}, bus.o_elapsed, exp_el);
  endtask

  initial begin
    int b, h;
    logic [31:0] a;
    bus.i_run = 0; bus.i_num_cycle = 0; bus.i_mem_reset_n = 1;
    bus.i_instr_write = 0; bus.i_instr_data = 0; bus.i_instr_addr = 0; bus.i_core_halt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_core_rst", bus.o_core_rst, 1);
    check("rst_core_en", bus.o_core_en, 0);
    check("rst_we", bus.o_imem_we, 0);
    check("rst_addr", bus.o_imem_addr, 0);
    check("rst_wdata", bus.o_imem_wdata, 0);
    check("rst_status", {bus.o_idle, bus.o_running, bus.o_done}, 3'b100);
    check("rst_flags", {bus.o_halted, bus.o_addr_err}, 2'b00);
    check("rst_elapsed", bus.o_elapsed, 0);
    step();

    do_write("w0", 32'h0, 32'h0000_0013);
    do_write("w1", 32'h4, 32'h0010_0093);
    do_write("w2", 32'h8, 32'h0000_0073);
    do_write("w_oob", 32'h1000, 32'hdead_beef);
    do_write("w_after_err", 32'hC, 32'h1234_5678);

    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1000) : {20'h0, 12'($urandom)};
      do_write($sformatf("wr%0d", i), a, $urandom);
    end

    do_run("b5", 5, 0);
    do_run("halt7", 0, 7);
    do_run("both7", 7, 7);
    do_run("halt1", 3, 1);
    for (int i = 0; i < 6; i++) begin
      b = $urandom_range(0, 20);
      h = (b == 0) ? $urandom_range(1, 25) : $urandom_range(0, 25);
      do_run($sformatf("rnd%0d", i), b, h);
    end

    // Write attempted mid-run: no strobe and no error.
    bus.i_num_cycle = 20; bus.i_run = 1; step(); step();
    bus.i_instr_addr = 32'h1000; bus.i_instr_write = 1; step();
    check("runwr_we", bus.o_imem_we, 0);
    check("runwr_err", bus.o_addr_err, 0);
    bus.i_instr_addr = 32'h10; step();
    check("runwr2_we", bus.o_imem_we, 0);
    bus.i_instr_write = 0;
    repeat (25) step();
    check("runwr_done", bus.o_done, 1);

    // Held i_run through DONE never restarts.
    repeat (4) step();
    check("hold_done", bus.o_done, 1);
    check("hold_en", bus.o_core_en, 0);
    check("hold_el", bus.o_elapsed, 20);
    bus.i_run = 0; step();
    check("drop_idle", bus.o_idle, 1);
    bus.i_num_cycle = 0; bus.i_run = 1; step();
    check("restart_run", bus.o_running, 1);
    check("restart_el", bus.o_elapsed, 0);

    // Synchronous abort during RUN cycle 3.
    step(); step();
    check("abort_pre_el", bus.o_elapsed, 2);
    bus.i_mem_reset_n = 0; step();
    check("abort_idle", bus.o_idle, 1);
    check("abort_core_rst", bus.o_core_rst, 1);
    check("abort_el", bus.o_elapsed, 0);
    bus.i_mem_reset_n = 1; step();
    check("abort_no_restart", bus.o_idle, 1);
    bus.i_run = 0; step();

    // Asynchronous reset mid-run.
    bus.i_num_cycle = 0; bus.i_run = 1; step(); step();
    check("ar_pre_run", bus.o_running, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_core_rst", bus.o_core_rst, 1);
    check("ar_core_en", bus.o_core_en, 0);
    check("ar_status", {bus.o_idle, bus.o_running, bus.o_done}, 3'b100);
    check("ar_elapsed", bus.o_elapsed, 0);
    bus.i_run = 0;
    @(negedge clk) rst = 1'b0;
    step();
    check("ar_after_idle", bus.o_idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
